// File: rtl/miss_handler.sv
// Cache miss sequencer: picks a victim way, writes back a dirty victim block,
// refills the block from memory word by word and installs the new tag.
module miss_handler #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int NWAYS     = 4,
  parameter int IDX_WIDTH = 6,
  parameter int WO_WIDTH  = 2,
  parameter int BO_WIDTH  = 2,
  parameter int TAG_WIDTH = PA_WIDTH - IDX_WIDTH - WO_WIDTH - BO_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       miss_req,
  input  logic [PA_WIDTH-1:0]        miss_addr,
  output logic                       ready,
  input  logic [NWAYS-1:0]           way_valid,
  input  logic [NWAYS-1:0]           way_dirty,
  input  logic [2*NWAYS-1:0]         way_lru,
  input  logic [TAG_WIDTH*NWAYS-1:0] way_tag,
  output logic [WO_WIDTH-1:0]        rd_word,
  input  logic [WRD_WIDTH-1:0]       rd_data,
  output logic [1:0]                 victim_way,
  output logic                       fill_we,
  output logic [WO_WIDTH-1:0]        fill_word,
  output logic [WRD_WIDTH-1:0]       fill_data,
  output logic                       install,
  output logic [TAG_WIDTH-1:0]       install_tag,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [PA_WIDTH-1:0]        mem_addr,
  output logic [WRD_WIDTH-1:0]       mem_wdata,
  input  logic [WRD_WIDTH-1:0]       mem_rdata,
  input  logic                       mem_ack,
  output logic                       done
);

  // state   | meaning
  // IDLE    | waiting for a miss, ready=1
  // SELECT  | choose victim way, latch its tag
  // WB      | write dirty victim words 0..WPB-1 to memory
  // REFILL  | read missing block words 0..WPB-1 into the array
  // INSTALL | write tag/valid/LRU for the victim way
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_WB      = 3'd2,
    S_REFILL  = 3'd3,
    S_INSTALL = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WO_WIDTH-1:0]    r_k;
  logic [WO_WIDTH-1:0]    w_k_next;
  logic [PA_WIDTH-1:0]    r_addr;
  logic [1:0]             r_victim;
  logic [TAG_WIDTH-1:0]   r_vtag;

  logic [1:0]             w_victim;
  logic [TAG_WIDTH-1:0]   w_vtag;
  logic                   w_vdirty;
  logic [IDX_WIDTH-1:0]   w_idx;
  logic [TAG_WIDTH-1:0]   w_mtag;
  logic                   w_unused;

  assign w_idx    = r_addr[BO_WIDTH+WO_WIDTH +: IDX_WIDTH];
  assign w_mtag   = r_addr[PA_WIDTH-1 -: TAG_WIDTH];
  assign w_unused = ^r_addr[BO_WIDTH+WO_WIDTH-1:0];

  // Invalid ways take priority over LRU; scanning downward leaves the lowest match.
  always_comb begin
    w_victim = '0;
    for (int i = NWAYS-1; i >= 0; i--) begin
      if (way_lru[2*i +: 2] == 2'(NWAYS-1)) w_victim = 2'(i);
    end
    for (int i = NWAYS-1; i >= 0; i--) begin
      if (!way_valid[i]) w_victim = 2'(i);
    end
  end

  assign w_vtag   = way_tag[TAG_WIDTH*w_victim +: TAG_WIDTH];
  assign w_vdirty = way_dirty[w_victim] && way_valid[w_victim];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_addr   <= '0;
      r_victim <= '0;
      r_vtag   <= '0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      if (r_state == S_IDLE && miss_req) r_addr <= miss_addr;
      if (r_state == S_SELECT) begin
        r_victim <= w_victim;
        r_vtag   <= w_vtag;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    case (r_state)
      S_IDLE: begin
        if (miss_req) begin
          w_next   = S_SELECT;
          w_k_next = '0;
        end
      end
      S_SELECT:  w_next = w_vdirty ? S_WB : S_REFILL;
      S_WB: begin
        if (mem_ack) begin
          w_k_next = r_k + 1'b1;
          if (&r_k) w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          w_k_next = r_k + 1'b1;
          if (&r_k) w_next = S_INSTALL;
        end
      end
      S_INSTALL: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (r_state == S_WB)
      mem_addr = {r_vtag, w_idx, r_k, {BO_WIDTH{1'b0}}};
    else if (r_state == S_REFILL)
      mem_addr = {w_mtag, w_idx, r_k, {BO_WIDTH{1'b0}}};
  end

  assign ready       = (r_state == S_IDLE);
  assign mem_req     = (r_state == S_WB) || (r_state == S_REFILL);
  assign mem_we      = (r_state == S_WB);
  assign mem_wdata   = (r_state == S_WB) ? rd_data : '0;
  assign rd_word     = r_k;
  assign fill_we     = (r_state == S_REFILL) && mem_ack;
  assign fill_word   = r_k;
  assign fill_data   = mem_rdata;
  assign install     = (r_state == S_INSTALL);
  assign install_tag = w_mtag;
  assign done        = (r_state == S_DONE);
  // During SELECT the choice is still combinational; afterwards it is held.
  assign victim_way  = (r_state == S_SELECT) ? w_victim : r_victim;

endmodule

// File: tb/tb_miss_handler.sv
// Scoreboard bench for miss_handler: a reference model queues expected memory
// beats, install and done events; a monitor pops and compares them.
module tb_miss_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        ready;
  logic [3:0]  way_valid;
  logic [3:0]  way_dirty;
  logic [7:0]  way_lru;
  logic [87:0] way_tag;
  logic [1:0]  rd_word;
  logic [31:0] rd_data;
  logic [1:0]  victim_way;
  logic        fill_we;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        install;
  logic [21:0] install_tag;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack = 1'b0;
  logic        done;

  miss_handler dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .ready(ready), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_lru(way_lru), .way_tag(way_tag), .rd_word(rd_word), .rd_data(rd_data),
    .victim_way(victim_way), .fill_we(fill_we), .fill_word(fill_word),
    .fill_data(fill_data), .install(install), .install_tag(install_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 write beat, 1 read beat, 2 install, 3 done
    logic [31:0] addr;
    logic [31:0] data;
    int          way;
    int          lat;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  accept_cyc = 0;
  int  last_done_cyc = 0;
  int  done_cnt = 0;
  int  cur_idx = 0;
  int  stall_mode = 0;   // -1 random stalls per beat, else fixed stall cycles
  int  wait_cnt = 0;
  int  cur_stall = 0;
  logic        prev_hold = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] arr_word(input int w, input int idx, input int k);
    logic [31:0] t;
    t = 32'(w * 1000 + idx * 10 + k);
    return (t * 32'h01000193) ^ 32'hC0DE0000;
  endfunction

  always_comb rd_data = arr_word(int'(victim_way), cur_idx, int'(rd_word));
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: fixed or random number of wait cycles before each ack.
  always @(posedge clk) begin
    #1;
    if (!mem_req) begin
      wait_cnt  = 0;
      cur_stall = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
      if (stall_mode == 0) mem_ack = 1'b1;
      else if (stall_mode < 0) mem_ack = 1'($urandom_range(0, 1));
      else mem_ack = 1'b0;
    end else if (wait_cnt >= cur_stall) begin
      mem_ack   = 1'b1;
      wait_cnt  = 0;
      cur_stall = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = wait_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
      return;
    end
    e = q.pop_front();
    if (kind != e.kind) begin
      fails++;
      $display("FAIL event_kind: got %0d expected %0d (exp addr %0h)", kind, e.kind, e.addr);
      return;
    end
    case (kind)
      0: if (mem_addr !== e.addr || mem_wdata !== e.data || victim_way !== 2'(e.way)) begin
           fails++;
           $display("FAIL wb_beat: got addr %0h data %0h way %0d expected addr %0h data %0h way %0d",
                    mem_addr, mem_wdata, victim_way, e.addr, e.data, e.way);
         end
      1: if (mem_addr !== e.addr || fill_we !== 1'b1 || fill_word !== e.addr[3:2] ||
             fill_data !== e.data || victim_way !== 2'(e.way)) begin
           fails++;
           $display("FAIL refill_beat: got addr %0h we %0b word %0d data %0h expected addr %0h word %0d data %0h",
                    mem_addr, fill_we, fill_word, fill_data, e.addr, e.addr[3:2], e.data);
         end
      2: if (install_tag !== e.data[21:0] || victim_way !== 2'(e.way)) begin
           fails++;
           $display("FAIL install: got tag %0h way %0d expected tag %0h way %0d",
                    install_tag, victim_way, e.data[21:0], e.way);
         end
      default: if (e.lat >= 0 && (cyc - accept_cyc) != e.lat) begin
           fails++;
           $display("FAIL done_latency: got %0d expected %0d", cyc - accept_cyc, e.lat);
         end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        tests++;
        if (!(mem_req && mem_we === p_we && mem_addr === p_addr && mem_wdata === p_wdata)) begin
          fails++;
          $display("FAIL hold_stable: got req %0b addr %0h data %0h expected addr %0h data %0h",
                   mem_req, mem_addr, mem_wdata, p_addr, p_wdata);
        end
      end
      if (ready && miss_req) accept_cyc = cyc;
      if (mem_req && mem_ack) observe(mem_we ? 0 : 1);
      else if (fill_we) begin
        tests++; fails++;
        $display("FAIL spurious_fill_we: got 1 expected 0");
      end
      if (install) observe(2);
      if (done) begin
        observe(3);
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_hold = mem_req && !mem_ack;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
    end
  end

  // Reference model: victim choice and event sequence straight from the rules.
  task automatic push_miss(input logic [31:0] a, input int stall);
    int v, idx, beats, lat;
    logic [21:0] mtag, vtag;
    logic [31:0] ad;
    bit wb;
    idx  = int'(a[9:4]);
    mtag = a[31:10];
    v = -1;
    for (int i = 0; i < 4; i++) if (!way_valid[i] && v < 0) v = i;
    if (v < 0) for (int i = 0; i < 4; i++) if (way_lru[2*i +: 2] == 2'd3 && v < 0) v = i;
    if (v < 0) v = 0;
    wb    = way_valid[v] && way_dirty[v];
    vtag  = way_tag[22*v +: 22];
    beats = wb ? 8 : 4;
    lat   = (stall >= 0) ? ((wb ? 11 : 7) + stall * beats) : -1;
    if (wb)
      for (int k = 0; k < 4; k++) begin
        ad = {vtag, 6'(idx), 2'(k), 2'b00};
        q.push_back('{0, ad, arr_word(v, idx, k), v, -1});
      end
    for (int k = 0; k < 4; k++) begin
      ad = {mtag, 6'(idx), 2'(k), 2'b00};
      q.push_back('{1, ad, mem_word(ad), v, -1});
    end
    q.push_back('{2, 32'h0, {10'h0, mtag}, v, -1});
    q.push_back('{3, 32'h0, 32'h0, v, lat});
    cur_idx = idx;
  endtask

  task automatic start_miss(input logic [31:0] a);
    bit ok;
    @(posedge clk); #1;
    miss_addr = a;
    miss_req  = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ready=0 expected 1");
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (done_cnt != start) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done");
    end
  endtask

  task automatic set_ways(input logic [3:0] v, input logic [3:0] d,
                          input logic [7:0] l, input logic [87:0] t);
    way_valid = v; way_dirty = d; way_lru = l; way_tag = t;
  endtask

  task automatic run_miss(input logic [31:0] a, input int stall);
    stall_mode = stall;
    push_miss(a, stall);
    start_miss(a);
    wait_done();
  endtask

  initial begin
    logic [31:0] a3;
    int dcnt;
    bit found;
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0;
    set_ways(4'h0, 4'h0, 8'h0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_fill_we", 32'(fill_we), 32'd0);
    chk("rst_install", 32'(install), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_victim", 32'(victim_way), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All ways invalid, clean refill into way 0.
    set_ways(4'h0, 4'h0, 8'h0, '0);
    run_miss(32'h0000_1230, 0);

    // Full set, way 2 is LRU and dirty.
    a3 = {22'h00123, 6'h23, 2'b00, 2'b00};
    set_ways(4'hF, 4'b0100, {2'd2, 2'd3, 2'd1, 2'd0},
             {22'h00333, 22'h00ABC, 22'h00111, 22'h00000});
    run_miss(a3, 0);
    run_miss(a3, 2);

    // Two LRU candidates, no dirty: lowest index wins.
    set_ways(4'hF, 4'h0, {2'd3, 2'd1, 2'd3, 2'd0},
             {22'h00004, 22'h00003, 22'h00002, 22'h00001});
    run_miss(32'h1234_5670, 0);

    // miss_req during REFILL ignored; back-to-back miss after done.
    stall_mode = 0;
    set_ways(4'b0111, 4'h0, 8'h00, {22'h0, 22'h00055, 22'h00066, 22'h00077});
    push_miss(32'h0ABC_0120, 0);
    push_miss(32'h0DEF_0128, 0);
    start_miss(32'h0ABC_0120);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (mem_req && !mem_we) begin found = 1; break; end
    end
    chk("refill_reached", 32'(found), 32'd1);
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'hFFFF_FFF0;
    @(negedge clk); #1;
    chk("busy_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    miss_req = 1'b0;
    wait_done();
    start_miss(32'h0DEF_0128);
    chk("b2b_accept_cycle", 32'(accept_cyc), 32'(last_done_cyc + 1));
    wait_done();

    // Reset in the middle of the second writeback beat.
    set_ways(4'hF, 4'b0001, {2'd0, 2'd1, 2'd2, 2'd3},
             {22'h00D04, 22'h00C03, 22'h00B02, 22'h00A01});
    stall_mode = 0;
    push_miss(32'h5555_0AA0, 0);
    start_miss(32'h5555_0AA0);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we && mem_addr[3:2] == 2'd1) begin found = 1; break; end
    end
    chk("wb_beat2_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    q.delete();
    dcnt = done_cnt;
    @(posedge clk); #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_install", 32'(install), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(dcnt));
    run_miss(32'h5555_0AA0, 0);

    // Randomized misses.
    for (int t = 0; t < 25; t++) begin
      set_ways(4'($urandom), 4'($urandom), 8'($urandom),
               {22'($urandom), 22'($urandom), 22'($urandom), 22'($urandom)});
      run_miss($urandom, int'($urandom_range(0, 3)) - 1);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
